// File: rtl/fiber_tx_sched.sv
// fiber_tx_sched
//   Sends one PRI's buffered radar data onto the fiber TX stream as a frame:
//   header word, 8 lanes x (Nr-1) RAM words read lane-major, tail word.
//   RAM reads are credit-limited into a small skid FIFO so that tx_ready
//   backpressure never loses or duplicates a word.
//
// Ports
//   clk_120m, FPGA_nRESET        clock, synchronous active-low reset
//   fibertx_en                   frame trigger (rising edge)
//   Nr, PRI_num, fpga_mode       frame parameters, sampled at trigger
//   ram_addrb/ram_sel/ram_enb    shared port-B read request to the 8 lanes
//   ram_doutb                    read data, RD_LAT cycles after ram_enb
//   tx_data/tx_valid/tx_ready    fiber TX word stream, tx_last marks the tail
//   busy                         FSM not idle
//   frame_cnt                    completed frames (wraps)
//   err_overrun                  sticky: trigger seen while busy
//
// state | meaning
// IDLE  | waiting for a trigger edge
// HDR   | presenting the header word
// READ  | issuing lane reads, forwarding FIFO words
// DRAIN | all reads issued, emptying pipeline and FIFO
// TAIL  | presenting the tail word (tx_last)

module fiber_tx_sched #(
  parameter int          ADDR_W        = 14,
  parameter int          RD_LAT        = 2,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter logic [15:0] TAIL_WORD     = 16'h09D7,
  // frame counter value after reset
  parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
  input  logic              clk_120m,
  input  logic              FPGA_nRESET,
  input  logic              fibertx_en,
  input  logic [15:0]       Nr,
  input  logic [9:0]        PRI_num,
  input  logic [7:0]        fpga_mode,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [2:0]        ram_sel,
  output logic              ram_enb,
  input  logic [127:0]      ram_doutb,
  output logic [127:0]      tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_overrun
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, HDR, READ, DRAIN, TAIL} state_t;

  state_t              state_q, state_d;
  logic                en_d_q;
  logic [15:0]         nr_q, nr_d;
  logic [9:0]          pri_q, pri_d;
  logic [7:0]          mode_q, mode_d;
  logic [2:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [127:0]        fifo_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [31:0]         data_cnt_q, data_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                err_q, err_d;

  logic                start, issue, push, pop, credit, fifo_empty, addr_last;
  logic [CW-1:0]       inflight;
  logic [15:0]         nr_m1;

  always_comb begin
    start      = fibertx_en & ~en_d_q;
    nr_m1      = nr_q - 16'd1;
    inflight   = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
    fifo_empty = (count_q == '0);
    // credit counts words already committed to the FIFO, so it can never overflow
    credit     = (count_q + inflight) < CW'(FIFO_DEPTH);
    issue      = (state_q == READ) & credit;
    push       = vld_q[RD_LAT-1];
    pop        = ((state_q == READ) | (state_q == DRAIN)) & ~fifo_empty & tx_ready;
    addr_last  = (16'(addr_q) == nr_m1);
  end

  always_comb begin
    vld_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d     = state_q;
    nr_d        = nr_q;
    pri_d       = pri_q;
    mode_d      = mode_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    data_cnt_d  = data_cnt_q + 32'(pop);
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q | (start & (state_q != IDLE));
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    tx_data     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nr_d       = Nr;
          pri_d      = PRI_num;
          mode_d     = fpga_mode;
          data_cnt_d = '0;
          state_d    = HDR;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = {SYNC_WORD, mode_q, 6'b0, pri_q, nr_q, frame_cnt_q, 56'b0};
        if (tx_ready) begin
          lane_d  = '0;
          addr_d  = ADDR_W'(1);
          state_d = (nr_q < 16'd2) ? TAIL : READ;
        end
      end
      READ: begin
        tx_valid = ~fifo_empty;
        tx_data  = fifo_q[rd_ptr_q];
        if (issue) begin
          if (addr_last) begin
            addr_d = ADDR_W'(1);
            lane_d = lane_q + 3'd1;
            if (lane_q == 3'd7) state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        tx_valid = ~fifo_empty;
        tx_data  = fifo_q[rd_ptr_q];
        // leave as the last word is taken so the tail follows without a bubble
        if ((inflight == '0) && (fifo_empty || ((count_q == CW'(1)) && pop)))
          state_d = TAIL;
      end
      TAIL: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = {TAIL_WORD, 16'h0, data_cnt_q, 64'b0};
        if (tx_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_120m) begin
    if (!FPGA_nRESET) begin
      state_q     <= IDLE;
      en_d_q      <= 1'b0;
      nr_q        <= '0;
      pri_q       <= '0;
      mode_q      <= '0;
      lane_q      <= '0;
      addr_q      <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_cnt_q  <= '0;
      frame_cnt_q <= FRAME_CNT_RST;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_d_q      <= fibertx_en;
      nr_q        <= nr_d;
      pri_q       <= pri_d;
      mode_q      <= mode_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_cnt_q  <= data_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk_120m) begin
    if (push) fifo_q[wr_ptr_q] <= ram_doutb;
  end

  assign ram_enb     = issue;
  assign ram_addrb   = issue ? addr_q : '0;
  assign ram_sel     = issue ? lane_q : '0;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign err_overrun = err_q;

endmodule

// File: doc/fiber_tx_sched.md
Name: fiber_tx_sched

Overview:
- Sequences transmission of one PRI's buffered radar data onto the fiber TX stream.
- Each frame is triggered by the fibertx_en window from the fiber address/write stage.
- Reads the eight dual-port RAM lanes (L1..L4, R1..R4) lane-major through a shared port-B address.
- Frames the data with a header and a tail word, and honours valid/ready backpressure from the fiber transmitter.

Parameters:
- ADDR_W, 14, RAM port-B address width.
- RD_LAT, 2, cycles from ram_addrb/ram_sel/ram_enb to valid ram_doutb.
- FIFO_DEPTH, 4, skid FIFO depth; must be ≥ RD_LAT+2.
- SYNC_WORD, 16'hEB90, header marker.
- TAIL_WORD, 16'h09D7, tail marker.

Ports:
- clk_120m  in  1  system clock, 120 MHz.
- FPGA_nRESET  in  1  reset, synchronous, active-low.
- fibertx_en  in  1  frame trigger; its rising edge starts a frame.
- Nr  in  16  RAM words per lane; valid data occupies addresses 1..Nr-1.
- PRI_num  in  10  PRI index, copied into the header.
- fpga_mode  in  8  mode code, copied into the header.
- ram_addrb  out  ADDR_W  port-B read address, shared by all lanes.
- ram_sel  out  3  lane select: 0-3 = L1-L4, 4-7 = R1-R4.
- ram_enb  out  1  read enable.
- ram_doutb  in  128  selected lane read data, valid RD_LAT cycles after ram_enb.
- tx_data  out  128  fiber TX word.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  fiber TX accepts the word.
- tx_last  out  1  marks the tail word.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_cnt  out  16  count of completed frames.
- err_overrun  out  1  sticky: a trigger arrived while busy.

Behaviour:
- Reset values: all outputs 0. The FSM goes to IDLE, the FIFO empties, and in-flight reads are discarded. Reset mid-frame aborts the frame; no tail is sent.
- Trigger: fibertx_en is registered once. start = en & ~en_d.
  - In IDLE, start latches Nr, PRI_num and fpga_mode into shadow registers and moves the FSM to HDR.
  - start while busy sets err_overrun and is otherwise ignored; the current frame continues on the latched values.
- FSM states: IDLE → HDR → READ → DRAIN → TAIL → IDLE.
- HDR:
  - tx_valid=1 on the cycle after start.
  - tx_data = {SYNC_WORD, fpga_mode, 6'b0, PRI_num, Nr, frame_cnt, 56'b0}.
  - On handshake: if Nr_latched < 2, go to TAIL; else go to READ.
- READ:
  - Issue reads at lane 0 addr 1..Nr-1, then lane 1, and so on through lane 7.
  - ram_enb=1 only when FIFO occupancy + reads in flight < FIFO_DEPTH (credit rule).
  - The address wraps from Nr-1 back to 1 with lane+1. After lane 7 addr Nr-1 is issued, go to DRAIN.
  - Returned data is pushed into the FIFO RD_LAT cycles after issue, tracked by an RD_LAT-deep valid shift register.
- Data beats: in READ and DRAIN, tx_valid = FIFO not empty and tx_data = FIFO head. The FIFO pops on tx_valid & tx_ready.
- DRAIN: when no reads are in flight and the FIFO is empty, go to TAIL.
- TAIL:
  - tx_data = {TAIL_WORD, 16'h0, data_cnt[31:0], 64'b0}, with tx_valid=1 and tx_last=1.
  - data_cnt counts accepted data beats, 32-bit, cleared at start.
  - On handshake: frame_cnt+1 (wraps 0xFFFF→0x0000), go to IDLE.
- Handshake rule: while tx_valid & ~tx_ready, tx_data and tx_last hold stable; tx_valid never drops without a handshake.
- Throughput: with tx_ready held at 1, the first data beat appears within RD_LAT+2 cycles of the header handshake. After that there are no bubbles until the last data beat, and the tail follows on the next cycle.
- Expected data beat count: 8·(Nr-1) for Nr ≥ 2, 0 otherwise. data_cnt must equal this; no beat is duplicated or lost under any tx_ready pattern.
- Mid-frame input changes: changes to Nr, PRI_num or fpga_mode during a frame have no effect until the next start.
- busy is high from the cycle after start through the tail handshake cycle.

Test Plan:
- Nr=4, PRI_num=5, fpga_mode=0x09, tx_ready=1, RAM model returning {lane,addr} → header, then 24 beats ordered L1a1..L1a3, L2a1, …, R4a3, then tail with data_cnt=24 and tx_last. 26 beats total, contiguous after fill; frame_cnt=1.
- Same frame with tx_ready randomly toggling at 50% → identical 26-word sequence; tx_data stable whenever stalled; FIFO occupancy never exceeds FIFO_DEPTH.
- Nr=1 and Nr=0 → header immediately followed by tail with data_cnt=0; ram_enb never asserted.
- Second fibertx_en rising edge during READ → err_overrun=1 and stays set; the running frame completes unchanged; no second header.
- FPGA_nRESET low for 1 cycle mid-READ → next cycle all outputs 0 and FSM in IDLE. The next trigger produces a clean frame with frame_cnt=0 in its header.
- Preload frame_cnt to 0xFFFF (65535 frames with Nr=1) → header carries 0xFFFF, and frame_cnt=0x0000 after the tail.
